// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: serializer state
// encoding and the default timing/buffer parameters.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // 230400 baud from a 100 MHz clock
    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int DEFAULT_FIFO_DEPTH   = 16;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head entry is always
// visible on o_data while o_empty is low.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;
    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_data   = r_mem[r_rdPtr];

    // Storage carries no reset; only the pointers and count define validity
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte-buffered 8N1 UART transmitter: a sync_fifo feeds a serializer that
// sends frames back to back with no idle gap while bytes are queued.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          in_ready,
    output logic                          tx_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CNTW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNTW-1:0] BIT_LAST = CNTW'(CLKS_PER_BIT - 1);

    tx_state_t       r_state;
    logic [CNTW-1:0] r_clkCnt;
    logic [2:0]      r_bitIdx;
    logic [7:0]      r_shift;
    logic            r_tx;

    logic            w_full;
    logic            w_empty;
    logic [7:0]      w_head;
    logic            w_push;
    logic            w_pop;
    logic            w_bitEnd;

    assign w_push   = in_valid && !w_full;
    assign w_bitEnd = (r_clkCnt == BIT_LAST);
    // Pop from IDLE, or on the final STOP cycle so the next start bit follows immediately
    assign w_pop    = !w_empty &&
                      ((r_state == IDLE) || ((r_state == STOP) && w_bitEnd));

    assign in_ready = !w_full;
    assign tx_out   = r_tx;
    assign busy     = (r_state != IDLE) || (fifo_count != '0);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    // The line level is registered from the current state, so it trails the
    // state by one cycle; every bit still lasts exactly CLKS_PER_BIT cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_clkCnt <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (!w_empty) begin
                        r_shift  <= w_head;
                        r_clkCnt <= '0;
                        r_state  <= START;
                    end
                end
                START: begin
                    r_tx <= 1'b0;
                    if (w_bitEnd) begin
                        r_clkCnt <= '0;
                        r_bitIdx <= '0;
                        r_state  <= DATA;
                    end else begin
                        r_clkCnt <= r_clkCnt + 1'b1;
                    end
                end
                DATA: begin
                    r_tx <= r_shift[0];
                    if (w_bitEnd) begin
                        r_clkCnt <= '0;
                        r_shift  <= {1'b0, r_shift[7:1]};
                        if (r_bitIdx == 3'd7) begin
                            r_state <= STOP;
                        end else begin
                            r_bitIdx <= r_bitIdx + 1'b1;
                        end
                    end else begin
                        r_clkCnt <= r_clkCnt + 1'b1;
                    end
                end
                STOP: begin
                    r_tx <= 1'b1;
                    if (w_bitEnd) begin
                        r_clkCnt <= '0;
                        if (!w_empty) begin
                            r_shift <= w_head;
                            r_state <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_clkCnt <= r_clkCnt + 1'b1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and randomized checks of uart_tx_fifo against an ideal line
// model and a mid-bit-sampling UART receiver.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       tx_out;
    logic       busy;
    logic [4:0] fifo_count;

    int assertCount = 0;
    int failCount   = 0;

    logic [7:0] expQ[$];
    int         rxCount = 0;
    logic       rxActive = 1'b0;
    logic       rxPrev = 1'b1;
    int         rxCycle = 0;
    int         rxIdx;
    logic [7:0] rxData = 8'h00;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .tx_out     (tx_out),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] data);
        in_valid = valid;
        in_data  = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ideal 8N1 line level k cycles after the start bit begins
    function automatic logic frameBit(input logic [7:0] b, input int k);
        int idx;
        idx = k / CPB;
        if (idx == 0) return 1'b0;
        else if (idx <= 8) return b[idx-1];
        else return 1'b1;
    endfunction

    task automatic waitDrain(input string tag, input int budget);
        int n;
        n = 0;
        while ((busy || expQ.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_queue"}, expQ.size(), 0);
    endtask

    // Handshake monitor and receiver model, both sampling on the falling edge
    initial forever begin
        @(negedge clk);
        if (!reset && in_valid && in_ready) expQ.push_back(in_data);
        if (reset) begin
            rxActive = 1'b0;
            rxPrev   = 1'b1;
        end else begin
            if (!rxActive) begin
                if (rxPrev && !tx_out) begin
                    rxActive = 1'b1;
                    rxCycle  = 0;
                end
            end else begin
                rxCycle++;
            end
            if (rxActive && (rxCycle % CPB) == CPB / 2) begin
                rxIdx = rxCycle / CPB;
                if (rxIdx == 0) begin
                    checkOutput("rx_start", tx_out, 0);
                end else if (rxIdx <= 8) begin
                    rxData[rxIdx-1] = tx_out;
                end else begin
                    checkOutput("rx_stop", tx_out, 1);
                    checkOutput("rx_pending", expQ.size() != 0, 1);
                    if (expQ.size() != 0) checkOutput("rx_byte", rxData, expQ.pop_front());
                    rxCount++;
                    rxActive = 1'b0;
                end
            end
            rxPrev = tx_out;
        end
    end

    initial begin
        int lowCycles;
        int sent;
        int cycles;
        int rxStart;
        logic accept;

        // Reset state
        reset = 1'b1;
        applyStimulus(1'b0, 8'h00);
        #1;
        checkOutput("reset_tx", tx_out, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_ready", in_ready, 1);
        checkOutput("reset_count", fifo_count, 0);
        tick();
        tick();

        // Single byte 0x55 accepted on the first edge after reset release
        reset = 1'b0;
        applyStimulus(1'b1, 8'h55);
        tick();
        applyStimulus(1'b0, 8'h00);
        checkOutput("t1_count_e0", fifo_count, 1);
        checkOutput("t1_tx_e0", tx_out, 1);
        tick();
        checkOutput("t1_count_pop", fifo_count, 0);
        checkOutput("t1_tx_pop", tx_out, 1);
        checkOutput("t1_busy", busy, 1);
        for (int k = 0; k < 10 * CPB; k++) begin
            tick();
            checkOutput("t1_line", tx_out, frameBit(8'h55, k));
        end
        checkOutput("t1_busy_end", busy, 0);
        tick();
        checkOutput("t1_idle_tx", tx_out, 1);
        waitDrain("t1_drain", 50);

        // Back-to-back frames 0xA5, 0x3C with push and pop on the same edge
        applyStimulus(1'b1, 8'hA5);
        tick();
        applyStimulus(1'b1, 8'h3C);
        tick();
        applyStimulus(1'b0, 8'h00);
        checkOutput("t2_count_pushpop", fifo_count, 1);
        for (int k = 0; k < 20 * CPB; k++) begin
            tick();
            checkOutput("t2_line", tx_out, (k < 10 * CPB) ? frameBit(8'hA5, k)
                                                          : frameBit(8'h3C, k - 10 * CPB));
        end
        tick();
        checkOutput("t2_idle_tx", tx_out, 1);
        waitDrain("t2_drain", 50);

        // Continuous offer until full, then no look-ahead on in_ready
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 8'h10 + 8'(i));
            tick();
        end
        checkOutput("t3_full_count", fifo_count, DEPTH);
        checkOutput("t3_full_ready", in_ready, 0);
        applyStimulus(1'b1, 8'h21);
        for (int i = 0; i < 24; i++) tick();
        checkOutput("t3_prepop_ready", in_ready, 0);
        checkOutput("t3_prepop_count", fifo_count, DEPTH);
        tick();
        checkOutput("t3_postpop_ready", in_ready, 1);
        checkOutput("t3_postpop_count", fifo_count, DEPTH - 1);
        tick();
        applyStimulus(1'b0, 8'h00);
        checkOutput("t3_refill_count", fifo_count, DEPTH);
        waitDrain("t3_drain", 1000);

        // Reset in the middle of data bit 3 with five bytes buffered
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 8'hC8 + 8'(i));
            tick();
        end
        applyStimulus(1'b0, 8'h00);
        checkOutput("t4_buffered", fifo_count, 5);
        for (int i = 0; i < 14; i++) tick();
        checkOutput("t4_bit3", tx_out, frameBit(8'hC8, 17));
        #2;
        reset = 1'b1;
        expQ.delete();
        #1;
        checkOutput("t4_rst_tx", tx_out, 1);
        checkOutput("t4_rst_count", fifo_count, 0);
        checkOutput("t4_rst_busy", busy, 0);
        checkOutput("t4_rst_ready", in_ready, 1);
        tick();
        tick();
        reset = 1'b0;
        lowCycles = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (!tx_out) lowCycles++;
        end
        checkOutput("t4_silent", lowCycles, 0);
        checkOutput("t4_busy_after", busy, 0);

        // All 256 byte values under random in_valid, verified by the receiver
        rxStart = rxCount;
        sent    = 0;
        cycles  = 0;
        while (sent < 256 && cycles < 20000) begin
            applyStimulus(($urandom_range(0, 3) != 0), 8'(sent));
            accept = in_valid && in_ready;
            tick();
            if (accept) sent++;
            cycles++;
        end
        applyStimulus(1'b0, 8'h00);
        checkOutput("t5_sent", sent, 256);
        waitDrain("t5_drain", 12000);
        checkOutput("t5_rx_count", rxCount - rxStart, 256);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
